// File: rtl/cv32e40p_obi_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cv32e40p_obi_sram_pkg
//  Description : Shared types and helpers for the OBI-to-SRAM bridge:
//                grant-owner encoding, response register layout and the
//                SRAM window check.
//  Revision    : 1.0  initial release
// ============================================================================
package cv32e40p_obi_sram_pkg;

    // Bit positions of the one-hot grant vector produced by the arbiter.
    localparam int unsigned c_gnt_instr = 0;
    localparam int unsigned c_gnt_data  = 1;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // State carried from the grant cycle into the response cycle.
    typedef struct packed {
        owner_e owner;
        logic   in_win;
        logic   valid;
    } rsp_reg_t;

    // True iff base <= addr < base + words*4. The arithmetic is done on 34
    // bits so that a window ending at 2^32 does not wrap.
    function automatic logic in_window(input logic [31:0]  addr,
                                       input logic [31:0]  base,
                                       input int unsigned  words);
        logic [33:0] span;
        logic [33:0] offs;
        span = {2'b00, words} << 2;
        offs = {2'b00, addr} - {2'b00, base};
        return (addr >= base) && (offs < span);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_obi_sram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cv32e40p_obi_sram_arb
//  Description : Two-port request arbiter producing a one-hot grant.
//                Default: fixed priority, data over instr.
//                With CV32E40P_OBI_SRAM_RR_ARB_EN defined: round-robin using
//                a 1-bit last-owner register (resets to instr).
//  Ports       : clk, rst  (clk only present in the round-robin build)
//                i_instr_req, i_data_req : requests
//                o_gnt[1:0]              : one-hot grant {data, instr}
//  Revision    : 1.0  initial release
// ============================================================================
module cv32e40p_obi_sram_arb
    import cv32e40p_obi_sram_pkg::*;
(
`ifdef CV32E40P_OBI_SRAM_RR_ARB_EN
    input  logic       clk,
`endif
    input  logic       rst,
    input  logic       i_instr_req,
    input  logic       i_data_req,
    output logic [1:0] o_gnt
);

    logic [1:0] w_gnt;

`ifdef CV32E40P_OBI_SRAM_RR_ARB_EN
    owner_e r_last_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= OWNER_INSTR;
        end else if (|w_gnt) begin
            r_last_owner <= w_gnt[c_gnt_data] ? OWNER_DATA : OWNER_INSTR;
        end
    end

    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            if (i_instr_req && i_data_req) begin
                // Contention: the port that did not win last time goes now.
                if (r_last_owner == OWNER_INSTR) begin
                    w_gnt[c_gnt_data] = 1'b1;
                end else begin
                    w_gnt[c_gnt_instr] = 1'b1;
                end
            end else begin
                w_gnt[c_gnt_data]  = i_data_req;
                w_gnt[c_gnt_instr] = i_instr_req;
            end
        end
    end
`else
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            w_gnt[c_gnt_data]  = i_data_req;
            w_gnt[c_gnt_instr] = i_instr_req && !i_data_req;
        end
    end
`endif

    assign o_gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_obi_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : cv32e40p_obi_sram_bridge
//  Description : Bridges the core's OBI instruction and data ports onto one
//                single-port SRAM with 1-cycle read latency. One access per
//                cycle; responses arrive exactly one cycle after the grant.
//                Accesses outside the SRAM window are granted and answered
//                with zero data, never reach the SRAM, and are recorded in a
//                sticky error flag plus first-offender address.
//  Options     : CV32E40P_OBI_SRAM_RR_ARB_EN -> round-robin arbitration
//                (default: data has fixed priority over instr)
//  Ports       : clk_i, rst_i (sync, active high)
//                instr_* : OBI instruction port (read only)
//                data_*  : OBI data port
//                sram_*  : SRAM macro interface
//                oob_err_o, oob_addr_o : out-of-window diagnostics
//  Revision    : 1.0  initial release
// ============================================================================
module cv32e40p_obi_sram_bridge
    import cv32e40p_obi_sram_pkg::*;
#(
    parameter  int unsigned MEM_WORDS = 16384,
    parameter  logic [31:0] ADDR_BASE = 32'h0000_0000,
    localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          instr_req_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    input  logic [31:0]   instr_addr_i,
    output logic [31:0]   instr_rdata_o,

    input  logic          data_req_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic [31:0]   data_rdata_o,

    output logic          sram_ce_o,
    output logic          sram_we_o,
    output logic [3:0]    sram_be_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i,

    output logic          oob_err_o,
    output logic [31:0]   oob_addr_o
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0] w_gnt;

    cv32e40p_obi_sram_arb u_arb (
`ifdef CV32E40P_OBI_SRAM_RR_ARB_EN
        .clk         (clk_i),
`endif
        .rst         (rst_i),
        .i_instr_req (instr_req_i),
        .i_data_req  (data_req_i),
        .o_gnt       (w_gnt)
    );

    logic w_gnt_data;
    logic w_any_gnt;
    assign w_gnt_data = w_gnt[c_gnt_data];
    assign w_any_gnt  = |w_gnt;

    // ------------------------------------------------------------------
    // Window check and SRAM drive
    // ------------------------------------------------------------------
    logic          w_instr_in_win;
    logic          w_data_in_win;
    logic          w_in_win;
    logic          w_ce;
    logic [AW-1:0] w_instr_waddr;
    logic [AW-1:0] w_data_waddr;
    logic [31:0]   w_req_addr;

    assign w_instr_in_win = in_window(instr_addr_i, ADDR_BASE, MEM_WORDS);
    assign w_data_in_win  = in_window(data_addr_i,  ADDR_BASE, MEM_WORDS);
    assign w_in_win       = w_gnt_data ? w_data_in_win : w_instr_in_win;
    assign w_req_addr     = w_gnt_data ? data_addr_i : instr_addr_i;

    // The base is aligned to the window size, so only the word-index bits
    // of the offset matter and no wider subtraction is needed.
    assign w_instr_waddr  = instr_addr_i[AW+1:2] - ADDR_BASE[AW+1:2];
    assign w_data_waddr   = data_addr_i[AW+1:2]  - ADDR_BASE[AW+1:2];

    assign w_ce           = w_any_gnt && w_in_win;

    assign sram_ce_o      = w_ce;
    assign sram_we_o      = w_ce && w_gnt_data && data_we_i;
    assign sram_be_o      = !w_ce     ? 4'h0 :
                            w_gnt_data ? data_be_i : 4'hF;
    assign sram_addr_o    = !w_any_gnt ? '0 :
                            w_gnt_data ? w_data_waddr : w_instr_waddr;
    assign sram_wdata_o   = w_gnt_data ? data_wdata_i : 32'h0;

    assign instr_gnt_o    = w_gnt[c_gnt_instr];
    assign data_gnt_o     = w_gnt_data;

    // ------------------------------------------------------------------
    // Response tracking
    // ------------------------------------------------------------------
    rsp_reg_t r_rsp;
    logic     r_rsp_wr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp    <= '0;
            r_rsp_wr <= 1'b0;
        end else begin
            r_rsp.valid  <= w_any_gnt;
            r_rsp.in_win <= w_in_win;
            r_rsp.owner  <= w_gnt_data ? OWNER_DATA : OWNER_INSTR;
            r_rsp_wr     <= w_gnt_data && data_we_i;
        end
    end

    logic        w_instr_rv;
    logic        w_data_rv;
    logic [31:0] w_rsp_rdata;

    // Qualifying with rst_i drops the response of a grant issued in the
    // cycle just before reset was asserted.
    assign w_instr_rv  = r_rsp.valid && (r_rsp.owner == OWNER_INSTR) && !rst_i;
    assign w_data_rv   = r_rsp.valid && (r_rsp.owner == OWNER_DATA)  && !rst_i;
    assign w_rsp_rdata = (r_rsp.in_win && !r_rsp_wr) ? sram_rdata_i : 32'h0;

    // Each port's rdata holds its last response while the other port owns
    // the SRAM.
    logic [31:0] r_instr_rdata;
    logic [31:0] r_data_rdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_instr_rdata <= 32'h0;
            r_data_rdata  <= 32'h0;
        end else begin
            if (w_instr_rv) begin
                r_instr_rdata <= w_rsp_rdata;
            end
            if (w_data_rv) begin
                r_data_rdata <= w_rsp_rdata;
            end
        end
    end

    assign instr_rvalid_o = w_instr_rv;
    assign data_rvalid_o  = w_data_rv;
    assign instr_rdata_o  = rst_i      ? 32'h0 :
                            w_instr_rv ? w_rsp_rdata : r_instr_rdata;
    assign data_rdata_o   = rst_i      ? 32'h0 :
                            w_data_rv  ? w_rsp_rdata : r_data_rdata;

    // ------------------------------------------------------------------
    // Out-of-window diagnostics (sticky until reset)
    // ------------------------------------------------------------------
    logic        r_oob_err;
    logic [31:0] r_oob_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_oob_err  <= 1'b0;
            r_oob_addr <= 32'h0;
        end else if (w_any_gnt && !w_in_win) begin
            r_oob_err <= 1'b1;
            if (!r_oob_err) begin
                r_oob_addr <= w_req_addr;
            end
        end
    end

    assign oob_err_o  = r_oob_err  && !rst_i;
    assign oob_addr_o = rst_i ? 32'h0 : r_oob_addr;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_obi_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cv32e40p_obi_sram_bridge
//  Description : Directed, table-driven bench for the OBI-to-SRAM bridge with
//                a behavioural 1-cycle-latency SRAM. Expected values depend on
//                CV32E40P_OBI_SRAM_RR_ARB_EN for the contention rows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cv32e40p_obi_sram_bridge;

    localparam int unsigned MEM_WORDS = 256;
    localparam logic [31:0] ADDR_BASE = 32'h0000_0000;
    localparam int unsigned AW        = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_req, instr_gnt, instr_rvalid;
    logic [31:0]   instr_addr, instr_rdata;
    logic          data_req, data_gnt, data_rvalid, data_we;
    logic [3:0]    data_be;
    logic [31:0]   data_addr, data_wdata, data_rdata;
    logic          sram_ce, sram_we;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;
    logic          oob_err;
    logic [31:0]   oob_addr;

    always #5 clk = ~clk;

    cv32e40p_obi_sram_bridge #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_BASE (ADDR_BASE)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_req_i    (instr_req),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_addr_i   (instr_addr),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_rdata_o   (data_rdata),
        .sram_ce_o      (sram_ce),
        .sram_we_o      (sram_we),
        .sram_be_o      (sram_be),
        .sram_addr_o    (sram_addr),
        .sram_wdata_o   (sram_wdata),
        .sram_rdata_i   (sram_rdata),
        .oob_err_o      (oob_err),
        .oob_addr_o     (oob_addr)
    );

    // Behavioural SRAM. Write cycles put junk on the read bus so that a
    // bridge forwarding sram_rdata_i for writes is visible.
    logic [31:0] mem [MEM_WORDS];
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
        sram_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                sram_rdata <= 32'hBAD0_C0DE;
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        igt;
        logic        dgt;
        logic        ce;
        logic        we;
        logic [3:0]  be;
        logic [7:0]  saddr;
        logic        irv;
        logic        drv;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        instr_req = 1'b0; instr_addr = 32'h0;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
    endtask

    task automatic apply(input vec_t v);
        instr_req = v.ireq; instr_addr = v.iaddr;
        data_req = v.dreq; data_we = v.dwe; data_be = v.dbe;
        data_addr = v.daddr; data_wdata = v.dwdata;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic [17:0] a_ctl, e_ctl;
        logic [31:0] a_ri, a_rd, e_ri, e_rd;
        a_ctl = {instr_gnt, data_gnt, sram_ce, sram_we, sram_be,
                 (v.ce ? sram_addr : 8'h0), instr_rvalid, data_rvalid};
        e_ctl = {v.igt, v.dgt, v.ce, v.we, v.be, v.saddr, v.irv, v.drv};
        a_ri  = v.irv ? instr_rdata : 32'h0;
        a_rd  = v.drv ? data_rdata  : 32'h0;
        e_ri  = v.irv ? v.irdata : 32'h0;
        e_rd  = v.drv ? v.drdata : 32'h0;
        chk($sformatf("vec%0d", idx), {28'h0, a_ctl, a_ri, a_rd}, {28'h0, e_ctl, e_ri, e_rd});
    endtask

    // Outputs that must all be zero in/after reset, packed for one compare.
    function automatic logic [95:0] all_outs();
        return {instr_gnt, instr_rvalid, data_gnt, data_rvalid,
                sram_ce, sram_we, sram_be, oob_err, oob_addr,
                instr_rdata ^ data_rdata, 19'h0};
    endfunction

    initial begin
        // {ireq,iaddr, dreq,dwe,dbe,daddr,dwdata, igt,dgt,ce,we,be,saddr, irv,drv,irdata,drdata}
        vecs[0]  = '{0,32'h0,   1,1,4'hF,32'h10, 32'hDEAD_BEEF, 0,1,1,1,4'hF,8'd4,   0,0,32'h0,32'h0};
        vecs[1]  = '{0,32'h0,   1,1,4'h3,32'h20, 32'h1234_5678, 0,1,1,1,4'h3,8'd8,   0,1,32'h0,32'h0};
        vecs[2]  = '{0,32'h0,   1,1,4'hF,32'h0,  32'h1111_0000, 0,1,1,1,4'hF,8'd0,   0,1,32'h0,32'h0};
        vecs[3]  = '{0,32'h0,   1,1,4'hF,32'h4,  32'h2222_0004, 0,1,1,1,4'hF,8'd1,   0,1,32'h0,32'h0};
        vecs[4]  = '{0,32'h0,   1,1,4'hF,32'h8,  32'h3333_0008, 0,1,1,1,4'hF,8'd2,   0,1,32'h0,32'h0};
        vecs[5]  = '{0,32'h0,   1,0,4'hF,32'h20, 32'h0,         0,1,1,0,4'hF,8'd8,   0,1,32'h0,32'h0};
        vecs[6]  = '{1,32'h10,  0,0,4'h0,32'h0,  32'h0,         1,0,1,0,4'hF,8'd4,   0,1,32'h0,32'h0000_5678};
        vecs[7]  = '{1,32'h0,   0,0,4'h0,32'h0,  32'h0,         1,0,1,0,4'hF,8'd0,   1,0,32'hDEAD_BEEF,32'h0};
        vecs[8]  = '{1,32'h4,   0,0,4'h0,32'h0,  32'h0,         1,0,1,0,4'hF,8'd1,   1,0,32'h1111_0000,32'h0};
        vecs[9]  = '{1,32'h8,   0,0,4'h0,32'h0,  32'h0,         1,0,1,0,4'hF,8'd2,   1,0,32'h2222_0004,32'h0};
        vecs[10] = '{0,32'h0,   0,0,4'h0,32'h0,  32'h0,         0,0,0,0,4'h0,8'd0,   1,0,32'h3333_0008,32'h0};
        vecs[11] = '{0,32'h0,   1,1,4'hF,32'h3FC,32'hA5A5_A5A5, 0,1,1,1,4'hF,8'd255, 0,0,32'h0,32'h0};
        vecs[12] = '{0,32'h0,   1,0,4'hF,32'h3FC,32'h0,         0,1,1,0,4'hF,8'd255, 0,1,32'h0,32'h0};
        vecs[13] = '{0,32'h0,   0,0,4'h0,32'h0,  32'h0,         0,0,0,0,4'h0,8'd0,   0,1,32'h0,32'hA5A5_A5A5};
        vecs[14] = '{1,32'h10,  0,0,4'h0,32'h0,  32'h0,         1,0,1,0,4'hF,8'd4,   0,0,32'h0,32'h0};
        vecs[15] = '{1,32'h4,   1,0,4'hF,32'h8,  32'h0,         0,1,1,0,4'hF,8'd2,   1,0,32'hDEAD_BEEF,32'h0};
`ifdef CV32E40P_OBI_SRAM_RR_ARB_EN
        vecs[16] = '{1,32'h4,   1,0,4'hF,32'h8,  32'h0,         1,0,1,0,4'hF,8'd1,   0,1,32'h0,32'h3333_0008};
        vecs[17] = '{1,32'h4,   1,0,4'hF,32'h8,  32'h0,         0,1,1,0,4'hF,8'd2,   1,0,32'h1111_0000,32'h0};
        vecs[18] = '{1,32'h4,   1,0,4'hF,32'h8,  32'h0,         1,0,1,0,4'hF,8'd1,   0,1,32'h0,32'h3333_0008};
        vecs[19] = '{0,32'h0,   0,0,4'h0,32'h0,  32'h0,         0,0,0,0,4'h0,8'd0,   1,0,32'h1111_0000,32'h0};
`else
        vecs[16] = '{1,32'h4,   1,0,4'hF,32'h8,  32'h0,         0,1,1,0,4'hF,8'd2,   0,1,32'h0,32'h3333_0008};
        vecs[17] = '{1,32'h4,   1,0,4'hF,32'h8,  32'h0,         0,1,1,0,4'hF,8'd2,   0,1,32'h0,32'h3333_0008};
        vecs[18] = '{1,32'h4,   1,0,4'hF,32'h8,  32'h0,         0,1,1,0,4'hF,8'd2,   0,1,32'h0,32'h3333_0008};
        vecs[19] = '{0,32'h0,   0,0,4'h0,32'h0,  32'h0,         0,0,0,0,4'h0,8'd0,   0,1,32'h0,32'h3333_0008};
`endif

        // ---------------- reset ----------------
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", all_outs(), 96'h0);
        chk("reset_rdata", {32'h0, instr_rdata, data_rdata}, 96'h0);

        // ---------------- table ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1 apply(vecs[i]);
            @(negedge clk);
            check_vec(i, vecs[i]);
        end

        // Non-owner/idle rdata holds last response.
        @(posedge clk); #1 idle();
        @(negedge clk);
`ifdef CV32E40P_OBI_SRAM_RR_ARB_EN
        chk("rdata_hold", {32'h0, instr_rdata, data_rdata}, {32'h0, 32'h1111_0000, 32'h3333_0008});
`else
        chk("rdata_hold", {32'h0, instr_rdata, data_rdata}, {32'h0, 32'hDEAD_BEEF, 32'h3333_0008});
`endif

        // ---------------- out-of-window ----------------
        @(posedge clk); #1
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h400;
        @(negedge clk);
        chk("oob1_grant", {91'h0, data_gnt, sram_ce, sram_we, oob_err, instr_gnt}, {91'h0, 5'b10000});
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("oob1_rsp", {data_rvalid, instr_rvalid, oob_err, 29'h0, data_rdata, oob_addr},
            {1'b1, 1'b0, 1'b1, 29'h0, 32'h0, 32'h400});
        @(posedge clk); #1 instr_req = 1'b1; instr_addr = 32'h8000_0000;
        @(negedge clk);
        chk("oob2_grant", {92'h0, instr_gnt, sram_ce, sram_be}, {92'h0, 2'b10, 4'h0});
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("oob2_rsp", {instr_rvalid, oob_err, 30'h0, instr_rdata, oob_addr},
            {1'b1, 1'b1, 30'h0, 32'h0, 32'h400});

        // ---------------- reset mid-access ----------------
        @(posedge clk); #1
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h10;
        @(negedge clk);
        chk("pre_rst_grant", {94'h0, data_gnt, sram_ce}, {94'h0, 2'b11});
        @(posedge clk); #1 idle(); rst = 1'b1; data_req = 1'b1; data_addr = 32'h20;
        @(negedge clk);
        chk("in_rst_outputs", all_outs(), 96'h0);
        chk("in_rst_rdata", {32'h0, instr_rdata, data_rdata}, 96'h0);
        @(posedge clk); #1 rst = 1'b0; idle();
        @(negedge clk);
        chk("post_rst_state", all_outs(), 96'h0);
        @(posedge clk); #1
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h20;
        @(negedge clk);
        chk("post_rst_grant", {86'h0, data_gnt, sram_ce, sram_addr}, {86'h0, 2'b11, 8'd8});
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("post_rst_rsp", {63'h0, data_rvalid, data_rdata}, {63'h0, 1'b1, 32'h0000_5678});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
